// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS test controller: FSM encoding and default widths.
package prbs_pkg;

  localparam int TMO_W_DEF  = 16;
  localparam int SEED_W_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/prbs_test_ctrl_if.sv
// Generator/detector side of the PRBS test controller: seed load, advance enable,
// repetition count out, match indication back.
interface prbs_test_ctrl_if
  import prbs_pkg::*;
#(
  parameter int SEED_W = SEED_W_DEF
);

  logic              prbs_load;
  logic [SEED_W-1:0] prbs_seed;
  logic              prbs_en;
  logic [7:0]        n_detec;
  logic              pattern_flag;

  modport master (
    output prbs_load, prbs_seed, prbs_en, n_detec,
    input  pattern_flag
  );

  modport slave (
    input  prbs_load, prbs_seed, prbs_en, n_detec,
    output pattern_flag
  );

endinterface

// File: rtl/prbs_test_ctrl.sv
// Sequences one PRBS test run: seed load, streaming until match/timeout/abort,
// then a done pulse with a sticky pass/fail verdict and the streamed byte count.
module prbs_test_ctrl
  import prbs_pkg::*;
#(
  parameter int TMO_W  = TMO_W_DEF,
  parameter int SEED_W = SEED_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic [7:0]        cfg_n,
  input  logic [TMO_W-1:0]  cfg_tmo,
  prbs_test_ctrl_if.master  gen,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [TMO_W-1:0]  byte_cnt
);

  state_t            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [7:0]        n_q, n_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              load_q, load_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TMO_W-1:0]  cnt_inc;
  logic [TMO_W-1:0]  timer_inc;

  always_comb begin
    cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q + TMO_W'(1);
    timer_inc = (&timer_q) ? timer_q : timer_q + TMO_W'(1);
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    n_d     = n_q;
    tmo_d   = tmo_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          seed_d  = cfg_seed;
          n_d     = cfg_n;
          tmo_d   = cfg_tmo;
          timer_d = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort || n_q == 8'd0) begin
          state_d = ST_FIN;
          fail_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d   = cnt_inc;
        timer_d = timer_inc;
        // abort beats a match; a match beats a timeout landing in the same cycle
        if (abort) begin
          state_d = ST_FIN;
          fail_d  = 1'b1;
        end else if (gen.pattern_flag) begin
          state_d = ST_FIN;
          pass_d  = 1'b1;
        end else if (tmo_q != '0 && timer_inc == tmo_q) begin
          state_d = ST_FIN;
          fail_d  = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they align with the state they describe
    load_d = (state_d == ST_LOAD);
    en_d   = (state_d == ST_RUN);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      n_q     <= '0;
      tmo_q   <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      n_q     <= n_d;
      tmo_q   <= tmo_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      load_q  <= load_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gen.prbs_load = load_q;
  assign gen.prbs_seed = seed_q;
  assign gen.prbs_en   = en_q;
  assign gen.n_detec   = n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign byte_cnt      = cnt_q;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Directed bench for prbs_test_ctrl: expected run results are queued at start and
// checked when done pulses; strobe counts are taken from a negedge monitor.
module tb_prbs_test_ctrl;
  import prbs_pkg::*;

  localparam int TMO_W  = 16;
  localparam int SEED_W = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [SEED_W-1:0] cfg_seed;
  logic [7:0]        cfg_n;
  logic [TMO_W-1:0]  cfg_tmo;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic [TMO_W-1:0]  byte_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int en_total = 0;
  int ld_total = 0;
  int done_total = 0;

  typedef struct {
    logic             pass;
    logic             fail;
    logic [TMO_W-1:0] cnt;
    int               en;
    int               ld;
  } exp_t;

  exp_t exp_q[$];

  prbs_test_ctrl_if #(.SEED_W(SEED_W)) bus();

  prbs_test_ctrl #(.TMO_W(TMO_W), .SEED_W(SEED_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg_seed (cfg_seed),
    .cfg_n    (cfg_n),
    .cfg_tmo  (cfg_tmo),
    .gen      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.prbs_en)   en_total   <= en_total + 1;
    if (bus.prbs_load) ld_total   <= ld_total + 1;
    if (done)          done_total <= done_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle index k: 0 = LOAD cycle, k>=1 = k-th RUN cycle. -1 disables an event.
  task automatic do_run(input logic [SEED_W-1:0] seed, input logic [7:0] n,
                        input logic [TMO_W-1:0] tmo, input int flag_cyc,
                        input int abort_cyc, input int restart_cyc, input logic fin_start,
                        input logic e_pass, input logic e_fail,
                        input logic [TMO_W-1:0] e_cnt, input int e_en);
    exp_t e;
    int   en0;
    int   ld0;
    bit   got;
    e.pass = e_pass;
    e.fail = e_fail;
    e.cnt  = e_cnt;
    e.en   = e_en;
    e.ld   = 1;
    exp_q.push_back(e);
    en0 = en_total;
    ld0 = ld_total;

    cfg_seed = seed;
    cfg_n    = n;
    cfg_tmo  = tmo;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("load_strobe", 32'(bus.prbs_load), 32'd1);
    chk("load_en",     32'(bus.prbs_en),   32'd0);
    chk("load_busy",   32'(busy),          32'd1);
    chk("load_clr",    32'({pass, fail}),  32'd0);
    chk("load_cnt",    32'(byte_cnt),      32'd0);

    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      bus.pattern_flag = (k == flag_cyc);
      abort            = (k == abort_cyc);
      if (k == restart_cyc) begin
        start    = 1'b1;
        cfg_seed = ~seed;
        cfg_n    = n + 8'd1;
        cfg_tmo  = 16'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("seed_held", 32'(bus.prbs_seed), 32'(seed));
      chk("n_held",    32'(bus.n_detec),   32'(n));
      if (done) got = 1'b1;
    end
    bus.pattern_flag = 1'b0;
    abort            = 1'b0;
    start            = 1'b0;

    chk("done_seen", 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      chk("fin_pass",  32'(pass),            32'(e.pass));
      chk("fin_fail",  32'(fail),            32'(e.fail));
      chk("fin_cnt",   32'(byte_cnt),        32'(e.cnt));
      chk("fin_busy",  32'(busy),            32'd0);
      chk("en_cycles", 32'(en_total - en0),  32'(e.en));
      chk("ld_cycles", 32'(ld_total - ld0),  32'(e.ld));
    end

    start = fin_start;
    tick();
    start = 1'b0;
    chk("idle_done", 32'(done),           32'd0);
    chk("idle_busy", 32'(busy),           32'd0);
    chk("idle_load", 32'(bus.prbs_load),  32'd0);
    chk("hold_pass", 32'(pass),           32'(e.pass));
    chk("hold_fail", 32'(fail),           32'(e.fail));
    chk("hold_cnt",  32'(byte_cnt),       32'(e.cnt));
    $display("run seed=%h n=%0d tmo=%0d -> pass=%0b fail=%0b byte_cnt=%0d",
             seed, n, tmo, pass, fail, byte_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    cfg_seed         = '0;
    cfg_n            = '0;
    cfg_tmo          = '0;
    bus.pattern_flag = 1'b0;
    #12;
    chk("rst_outs", 32'({bus.prbs_load, bus.prbs_en, busy, done, pass, fail}), 32'd0);
    chk("rst_seed", 32'(bus.prbs_seed), 32'd0);
    chk("rst_n",    32'(bus.n_detec),   32'd0);
    chk("rst_cnt",  32'(byte_cnt),      32'd0);
    tick();
    rst = 1'b0;

    // normal pass, match on RUN cycle 8
    do_run(15'h7FFF, 8'd2, 16'd100, 8, -1, -1, 1'b0, 1'b1, 1'b0, 16'd8, 8);
    // timeout after 5 RUN cycles
    do_run(15'h1234, 8'd3, 16'd5, -1, -1, -1, 1'b0, 1'b0, 1'b1, 16'd5, 5);
    // match coinciding with timeout: pass wins
    do_run(15'h0F0F, 8'd1, 16'd3, 3, -1, -1, 1'b0, 1'b1, 1'b0, 16'd3, 3);
    // abort and match together on RUN cycle 2: abort wins
    do_run(15'h5555, 8'd2, 16'd0, 2, 2, -1, 1'b0, 1'b0, 1'b1, 16'd2, 2);
    // cfg_n == 0: LOAD straight to FIN; start held through FIN must not be queued
    do_run(15'h0001, 8'd0, 16'd10, -1, -1, -1, 1'b1, 1'b0, 1'b1, 16'd0, 0);

    // reset in RUN cycle 4
    cfg_seed = 15'h2222;
    cfg_n    = 8'd3;
    cfg_tmo  = 16'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_cnt", 32'(byte_cnt), 32'd3);
    d0 = done_total;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outs", 32'({bus.prbs_load, bus.prbs_en, busy, done, pass, fail}), 32'd0);
    chk("arst_seed", 32'(bus.prbs_seed), 32'd0);
    chk("arst_n",    32'(bus.n_detec),   32'd0);
    chk("arst_cnt",  32'(byte_cnt),      32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("arst_nodone", 32'(done_total - d0), 32'd0);
    $display("reset mid-run: outputs cleared, no done pulse");

    // start accepted in the first cycle after reset release
    do_run(15'h002A, 8'd4, 16'd0, 6, -1, -1, 1'b0, 1'b1, 1'b0, 16'd6, 6);
    // start and cfg changes while busy are ignored
    do_run(15'h1357, 8'd7, 16'd0, 6, -1, 2, 1'b0, 1'b1, 1'b0, 16'd6, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
